rr_arbiter_16: RTL and testbench



---
 rtl/rr_arbiter_16.sv | 169 ++++++++++++++++
 tb/tb_rr_arbiter_16.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// Sixteen-requester round-robin arbiter with a registered one-hot grant and a mandatory idle cycle between grants.
// Optional hold-time limit: define RR_ARB_TIMEOUT_EN to revoke grants held for HOLD_MAX cycles.
module rr_arbiter_16 #(
  parameter int unsigned NUM_REQ  = 16,
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic               timeout
);

  localparam int unsigned IDX_W = 4;

  // The downstream 16-to-4 encoder fixes the width; reject anything else at elaboration.
  if (NUM_REQ != 16) begin : g_bad_num_req
    $error("rr_arbiter_16: NUM_REQ must be 16");
  end
  if (HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_bad_hold_max
    $error("rr_arbiter_16: HOLD_MAX must be in 2..65535");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   own_q, own_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               grant_valid_q, grant_valid_d;

  logic               pick_found_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               tmo_hit_c;
  logic               other_cause_c;
  logic               release_c;

  // First requester at or above ptr, wrapping 15 -> 0.
  always_comb begin
    pick_found_c = 1'b0;
    pick_idx_c   = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found_c && req[IDX_W'(ptr_q + IDX_W'(k))]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = IDX_W'(ptr_q + IDX_W'(k));
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign tmo_hit_c = (state_q == S_GRANT) && (cnt_q == CNT_W'(HOLD_MAX));
`else
  assign tmo_hit_c = 1'b0;
`endif

  assign other_cause_c = done || !req[own_q] || !enable;
  assign release_c     = (state_q == S_GRANT) && (other_cause_c || tmo_hit_c);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && pick_found_c) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (release_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (enable && pick_found_c) begin
          own_d   = pick_idx_c;
          grant_d = NUM_REQ'(1) << pick_idx_c;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      S_GRANT: begin
        if (release_c) begin
          grant_d = '0;
          ptr_d   = IDX_W'(own_q + IDX_W'(1));
`ifdef RR_ARB_TIMEOUT_EN
          // Flag the revocation only when the limit is the sole reason.
          timeout_d = tmo_hit_c && !other_cause_c;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
`endif
        end
      end
      default: grant_d = '0;
    endcase
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= '0;
      own_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      own_q         <= own_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against a behavioural arbiter model.
module tb_rr_arbiter_16;

  localparam int unsigned TB_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic        grant_valid;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter_16 #(.NUM_REQ(16), .HOLD_MAX(TB_HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner is -1 when nobody holds the resource.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_held  = 0;
  logic [15:0] m_grant = '0;
  logic        m_to    = 1'b0;

  task automatic model_edge(input logic rst, input logic en, input logic [15:0] r, input logic d);
    bit lim;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_grant = '0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      m_grant = '0;
      if (en && r != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % 16]) m_owner = (m_ptr + k) % 16;
        end
        m_grant = 16'(1) << m_owner;
        m_held = 1;
      end
    end else begin
      lim = TMO_EN && (m_held == int'(TB_HOLD));
      if (d || !r[m_owner] || !en || lim) begin
        m_to = lim && !d && r[m_owner] && en;
        m_ptr = (m_owner + 1) % 16;
        m_owner = -1;
        m_grant = '0;
        m_held = 0;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [15:0] r, input logic d);
    reset = rst; enable = en; req = r; done = d;
    @(posedge clk);
    model_edge(rst, en, r, d);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp_g, input logic exp_to);
    total++;
    if (grant !== exp_g || grant_valid !== (exp_g != 16'h0) || timeout !== exp_to) begin
      bad++;
      $display("FAIL %s: got grant=%h valid=%b timeout=%b, want grant=%h valid=%b timeout=%b",
               name, grant, grant_valid, timeout, exp_g, (exp_g != 16'h0), exp_to);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        done;
    logic [15:0] exp_g;
    logic        exp_to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic [15:0] r, input logic d,
                     input logic [15:0] g);
    vec_t v;
    v.rst = rst; v.en = en; v.req = r; v.done = d; v.exp_g = g; v.exp_to = 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; req = '0; done = 1'b0;

    // Reset, single request held three cycles, done releases; ptr -> 1
    add(1, 0, 16'h0000, 0, 16'h0000);
    add(0, 1, 16'h0001, 0, 16'h0001);
    add(0, 1, 16'h0001, 0, 16'h0001);
    add(0, 1, 16'h0001, 0, 16'h0001);
    add(0, 1, 16'h0001, 1, 16'h0000);
    // Rotation with all requesting; each grant followed by an idle cycle
    for (int i = 1; i < 16; i++) begin
      add(0, 1, 16'hFFFF, 0, 16'(1) << i);
      add(0, 1, 16'hFFFF, 1, 16'h0000);
    end
    add(0, 1, 16'hFFFF, 0, 16'h0001);
    add(0, 1, 16'hFFFF, 1, 16'h0000);
    // Move ptr to 5, then search wraps past 15
    add(0, 1, 16'h0010, 0, 16'h0010);
    add(0, 1, 16'h0010, 1, 16'h0000);
    add(0, 1, 16'h0011, 0, 16'h0001);
    add(0, 1, 16'h0011, 1, 16'h0000);
    add(0, 1, 16'h0011, 0, 16'h0010);
    add(0, 1, 16'h0011, 1, 16'h0000);
    // Owner 3 drops its request
    add(0, 1, 16'h0008, 0, 16'h0008);
    add(0, 1, 16'h0008, 0, 16'h0008);
    add(0, 1, 16'h0000, 0, 16'h0000);
    // Enable drop releases and blocks new grants
    add(0, 1, 16'h0020, 0, 16'h0020);
    add(0, 0, 16'h0020, 0, 16'h0000);
    add(0, 0, 16'h0020, 0, 16'h0000);
    add(0, 0, 16'h0020, 0, 16'h0000);
    add(0, 1, 16'h0020, 0, 16'h0020);
    add(0, 1, 16'h0020, 1, 16'h0000);
    // Reset mid-grant clears grant and ptr
    add(0, 1, 16'h0100, 0, 16'h0100);
    add(1, 1, 16'h0100, 0, 16'h0000);
    add(0, 1, 16'h0101, 0, 16'h0001);
    add(0, 1, 16'h0101, 1, 16'h0000);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d", i), vecs[i].exp_g, vecs[i].exp_to);
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Grant revoked after exactly TB_HOLD cycles; ptr advances to 3
    step(1, 0, 16'h0000, 0);
    check("to_reset", 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h0004, 0);
      check("to_hold", 16'h0004, 1'b0);
    end
    step(0, 1, 16'h0004, 0);
    check("to_fire", 16'h0000, 1'b1);
    step(0, 1, 16'h000C, 0);
    check("to_ptr3", 16'h0008, 1'b0);
    step(0, 1, 16'h000C, 1);
    check("to_rel", 16'h0000, 1'b0);
    // done on the fourth cycle suppresses the pulse
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h0004, 0);
      check("to_done_hold", 16'h0004, 1'b0);
    end
    step(0, 1, 16'h0004, 1);
    check("to_done_rel", 16'h0000, 1'b0);
    // Dropped request on the fourth cycle also suppresses it
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h0004, 0);
      check("to_drop_hold", 16'h0004, 1'b0);
    end
    step(0, 1, 16'h0000, 0);
    check("to_drop_rel", 16'h0000, 1'b0);
`else
    // Without the limit a grant is held indefinitely
    step(1, 0, 16'h0000, 0);
    check("hold_reset", 16'h0000, 1'b0);
    for (int i = 0; i < 110; i++) begin
      step(0, 1, 16'h0004, 0);
      check("hold_long", 16'h0004, 1'b0);
    end
    step(0, 1, 16'h0004, 1);
    check("hold_rel", 16'h0000, 1'b0);
`endif

    // Randomized traffic against the model
    step(1, 0, 16'h0000, 0);
    check("rnd_reset", m_grant, m_to);
    begin
      logic [15:0] r;
      logic        en;
      r  = 16'h0;
      en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(9) < 3) begin
          case ($urandom_range(3))
            0: r = 16'h0;
            1: r = 16'(1) << $urandom_range(15);
            2: r = 16'($urandom & $urandom & $urandom);
            default: r = 16'($urandom);
          endcase
        end
        if ($urandom_range(19) == 0) en = ~en;
        step(($urandom_range(299) == 0), en, r, ($urandom_range(5) == 0));
        check("rnd", m_grant, m_to);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
